watch_core: RTL and testbench

- Parametrised timekeeping core: hh:mm:ss counter plus NUM_ALARMS independent alarm channels, ring timeout and snooze.
- Supersedes the single-alarm clock/alarm pair. Sits between the debounced/pulsed button logic and the display output logic.
- Consumes the system clock directly and derives its own 1 Hz tick with an internal prescaler.

---
 rtl/watch_core.sv | 183 ++++++++++++++++++
 tb/tb_watch_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_core.sv
// Timekeeping core: hh:mm:ss counter, NUM_ALARMS alarm channels, ring timeout and snooze.
// Optional macro WATCH_CORE_HOUR12_EN adds a pm output and presents hour in 12-hour form.
module watch_core #(
    parameter int NUM_ALARMS = 4,
    parameter int TICK_DIV   = 100,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_time_wr,
    input  logic [4:0]            set_hour,
    input  logic [5:0]            set_min,
    input  logic [5:0]            set_sec,
    input  logic                  alm_wr,
    input  logic [AW-1:0]         alm_idx,
    input  logic [4:0]            alm_hour,
    input  logic [5:0]            alm_min,
    input  logic                  alm_en,
    input  logic                  aoff,
    input  logic                  snooze,
    output logic [4:0]            hour,
    output logic [5:0]            min,
    output logic [5:0]            sec,
    output logic                  sec_pulse,
    output logic                  ring,
    output logic [NUM_ALARMS-1:0] ring_mask,
    output logic                  snoozing
`ifdef WATCH_CORE_HOUR12_EN
    ,
    output logic                  pm
`endif
);
    localparam int PW       = $clog2(TICK_DIV);
    localparam int SNZ_SECS = SNOOZE_MIN * 60;
    localparam int SW       = $clog2(SNZ_SECS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNZ_SECS);
    localparam logic [7:0]    RING_LOAD  = 8'(RING_SECS);

    logic [PW-1:0]         presc_reg;
    logic [4:0]            hour_reg, hour_inc;
    logic [5:0]            min_reg, min_inc, sec_reg, sec_inc;
    logic                  pulse_reg;
    logic                  tick, set_ok, alm_ok;
    logic [NUM_ALARMS-1:0] match, hit, mask_reg, saved_reg, base_mask, add_bits, new_bits;
    logic [7:0]            rtimer_reg;
    logic [SW-1:0]         snz_reg;
    logic                  ring_int, snz_take, expire, restore;

    assign tick   = (presc_reg == PRESC_LAST);
    assign set_ok = set_time_wr && (set_hour < 5'd24) && (set_min < 6'd60) && (set_sec < 6'd60);
    assign alm_ok = alm_wr && (alm_hour < 5'd24) && (alm_min < 6'd60);

    always_comb begin
        sec_inc  = sec_reg + 6'd1;
        min_inc  = min_reg;
        hour_inc = hour_reg;
        if (sec_reg == 6'd59) begin
            sec_inc = 6'd0;
            if (min_reg == 6'd59) begin
                min_inc  = 6'd0;
                hour_inc = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
            end else begin
                min_inc = min_reg + 6'd1;
            end
        end
    end

    // A valid time load wins over a coincident tick and suppresses its pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
            hour_reg  <= '0;
            min_reg   <= '0;
            sec_reg   <= '0;
            pulse_reg <= 1'b0;
        end else if (set_ok) begin
            presc_reg <= '0;
            hour_reg  <= set_hour;
            min_reg   <= set_min;
            sec_reg   <= set_sec;
            pulse_reg <= 1'b0;
        end else if (tick) begin
            presc_reg <= '0;
            hour_reg  <= hour_inc;
            min_reg   <= min_inc;
            sec_reg   <= sec_inc;
            pulse_reg <= 1'b1;
        end else begin
            presc_reg <= presc_reg + PW'(1);
            pulse_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alm
        logic [4:0] a_hour_reg;
        logic [5:0] a_min_reg;
        logic       a_en_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_hour_reg <= '0;
                a_min_reg  <= '0;
                a_en_reg   <= 1'b0;
            end else if (alm_ok && (alm_idx == AW'(gi))) begin
                a_hour_reg <= alm_hour;
                a_min_reg  <= alm_min;
                a_en_reg   <= alm_en;
            end
        end

        assign match[gi] = a_en_reg && (a_hour_reg == hour_reg) && (a_min_reg == min_reg);
    end

    // Matches only count on the cycle a freshly ticked time is visible.
    assign hit      = (pulse_reg && (sec_reg == 6'd0)) ? match : '0;
    assign ring_int = |mask_reg;
    assign snz_take = snooze && ring_int;
    assign expire   = pulse_reg && ring_int && (rtimer_reg == 8'd1);
    assign restore  = pulse_reg && (snz_reg == SW'(1)) && !snz_take;

    always_comb begin
        base_mask = (snz_take || expire) ? '0 : mask_reg;
        add_bits  = hit | (restore ? saved_reg : '0);
        new_bits  = add_bits & ~base_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_reg   <= '0;
            saved_reg  <= '0;
            rtimer_reg <= '0;
            snz_reg    <= '0;
        end else if (aoff) begin
            mask_reg   <= '0;
            saved_reg  <= '0;
            rtimer_reg <= '0;
            snz_reg    <= '0;
        end else begin
            mask_reg <= base_mask | add_bits;

            if (snz_take)
                saved_reg <= mask_reg;
            else if (restore)
                saved_reg <= '0;

            if (snz_take)
                snz_reg <= SNZ_LOAD;
            else if (pulse_reg && (snz_reg != '0))
                snz_reg <= snz_reg - SW'(1);

            if ((new_bits != '0) || restore)
                rtimer_reg <= RING_LOAD;
            else if (snz_take || expire)
                rtimer_reg <= 8'd0;
            else if (pulse_reg && ring_int)
                rtimer_reg <= rtimer_reg - 8'd1;
        end
    end

    assign min       = min_reg;
    assign sec       = sec_reg;
    assign sec_pulse = pulse_reg;
    assign ring      = ring_int;
    assign ring_mask = mask_reg;
    assign snoozing  = (snz_reg != '0);

`ifdef WATCH_CORE_HOUR12_EN
    always_comb begin
        pm   = (hour_reg >= 5'd12);
        hour = hour_reg;
        if (hour_reg == 5'd0)
            hour = 5'd12;
        else if (hour_reg > 5'd12)
            hour = hour_reg - 5'd12;
    end
`else
    assign hour = hour_reg;
`endif

endmodule

// File: tb/tb_watch_core.sv
// Randomised and directed bench for watch_core against a seconds-of-day reference model.
module tb_watch_core;
    localparam int NA   = 4;
    localparam int TD   = 4;
    localparam int RS   = 5;
    localparam int SM   = 1;
    localparam int SNZN = SM * 60;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set_time_wr = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0, set_sec = '0;
    logic       alm_wr = 1'b0;
    logic [1:0] alm_idx = '0;
    logic [4:0] alm_hour = '0;
    logic [5:0] alm_min = '0;
    logic       alm_en = 1'b0;
    logic       aoff = 1'b0, snooze = 1'b0;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic       sec_pulse, ring, snoozing;
    logic [NA-1:0] ring_mask;
`ifdef WATCH_CORE_HOUR12_EN
    logic       pm;
`endif

    watch_core #(.NUM_ALARMS(NA), .TICK_DIV(TD), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clk(clk), .reset(reset),
        .set_time_wr(set_time_wr), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .alm_wr(alm_wr), .alm_idx(alm_idx), .alm_hour(alm_hour), .alm_min(alm_min), .alm_en(alm_en),
        .aoff(aoff), .snooze(snooze),
        .hour(hour), .min(min), .sec(sec), .sec_pulse(sec_pulse),
        .ring(ring), .ring_mask(ring_mask), .snoozing(snoozing)
`ifdef WATCH_CORE_HOUR12_EN
        , .pm(pm)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int npulse = 0;

    // Reference model: time kept as seconds of the day, channels as plain arrays.
    int m_tod, m_presc, m_pulse, m_mask, m_saved, m_rt, m_sc;
    int m_ah[NA], m_am[NA], m_ae[NA];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int disp_hour(input int h);
`ifdef WATCH_CORE_HOUR12_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
`endif
        return h;
    endfunction

    task automatic m_reset();
        m_tod = 0; m_presc = 0; m_pulse = 0;
        m_mask = 0; m_saved = 0; m_rt = 0; m_sc = 0;
        for (int i = 0; i < NA; i++) begin
            m_ah[i] = 0; m_am[i] = 0; m_ae[i] = 0;
        end
    endtask

    task automatic m_step();
        int old_ring, m, s, r, c, add, restore, hitv;
        old_ring = (m_mask != 0);
        hitv = 0;
        if (m_pulse != 0 && (m_tod % 60) == 0)
            for (int i = 0; i < NA; i++)
                if (m_ae[i] != 0 && m_ah[i] == m_tod / 3600 && m_am[i] == (m_tod / 60) % 60)
                    hitv |= (1 << i);
        m = m_mask; s = m_saved; r = m_rt; c = m_sc; restore = 0;
        if (aoff) begin
            m = 0; s = 0; r = 0; c = 0;
        end else begin
            if (snooze && old_ring != 0) begin
                s = m; m = 0; c = SNZN; r = 0;
            end else if (m_pulse != 0) begin
                if (old_ring != 0) begin
                    if (r == 1) begin m = 0; r = 0; end
                    else r = r - 1;
                end
                if (c > 0) begin
                    c = c - 1;
                    if (c == 0) restore = 1;
                end
            end
            add = hitv | (restore != 0 ? s : 0);
            if (restore != 0) s = 0;
            if ((add & ~m) != 0 || restore != 0) r = RS;
            m = m | add;
        end
        m_mask = m; m_saved = s; m_rt = r; m_sc = c;
        if (set_time_wr && set_hour < 24 && set_min < 60 && set_sec < 60) begin
            m_tod = set_hour * 3600 + set_min * 60 + set_sec;
            m_presc = 0; m_pulse = 0;
        end else if (m_presc == TD - 1) begin
            m_tod = (m_tod + 1) % 86400;
            m_presc = 0; m_pulse = 1;
        end else begin
            m_presc++; m_pulse = 0;
        end
        if (alm_wr && int'(alm_idx) < NA && alm_hour < 24 && alm_min < 60) begin
            m_ah[alm_idx] = alm_hour; m_am[alm_idx] = alm_min; m_ae[alm_idx] = alm_en;
        end
    endtask

    task automatic compare_all();
        check("hour", hour, disp_hour(m_tod / 3600));
`ifdef WATCH_CORE_HOUR12_EN
        check("pm", pm, (m_tod / 3600) >= 12);
`endif
        check("min", min, (m_tod / 60) % 60);
        check("sec", sec, m_tod % 60);
        check("sec_pulse", sec_pulse, m_pulse);
        check("ring", ring, m_mask != 0);
        check("ring_mask", ring_mask, m_mask);
        check("snoozing", snoozing, m_sc != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) m_reset();
        else m_step();
        #1;
        compare_all();
        if (sec_pulse) npulse++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        $display("set_time %0d:%0d:%0d", h, m, s);
        set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s); set_time_wr = 1'b1;
        cycle();
        set_time_wr = 1'b0;
    endtask

    task automatic write_alarm(input int idx, input int h, input int m, input int en);
        $display("alarm ch%0d %0d:%0d en=%0d", idx, h, m, en);
        alm_idx = 2'(idx); alm_hour = 5'(h); alm_min = 6'(m); alm_en = en[0]; alm_wr = 1'b1;
        cycle();
        alm_wr = 1'b0;
    endtask

    task automatic strobe(input logic a, input logic s);
        $display("strobe aoff=%0b snooze=%0b", a, s);
        aoff = a; snooze = s;
        cycle();
        aoff = 1'b0; snooze = 1'b0;
    endtask

    task automatic wait_ring(input int max, input string tag);
        int k = 0;
        while (!ring && k < max) begin
            cycle();
            k++;
        end
        check(tag, ring, 1);
    endtask

    task automatic do_reset();
        $display("async reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_reset();
        compare_all();
        run(2);
        reset = 1'b1;
    endtask

    initial begin
        m_reset();
        run(2);
        reset = 1'b1;

        // Prescaler: 16 cycles give four seconds.
        npulse = 0;
        run(16);
        check("pulses16", npulse, 4);
        check("sec16", sec, 4);
        check("min16", min, 0);

        // Midnight wrap and a rejected out-of-range load.
        set_time(23, 59, 59);
        run(TD);
        check("wrap_hour", hour, disp_hour(0));
        check("wrap_min", min, 0);
        check("wrap_sec", sec, 0);
        set_time(24, 30, 30);
        check("bad_set_hour", hour, disp_hour(0));
        check("bad_set_min", min, 0);
        check("bad_set_sec", sec, 0);

        // Two channels on the same minute, then ring timeout.
        write_alarm(0, 7, 0, 1);
        write_alarm(2, 7, 0, 1);
        set_time(6, 59, 58);
        wait_ring(3 * TD + 4, "ring_on");
        check("mask_0101", ring_mask, 5);
        run(RS * TD - 1);
        check("ring_before_timeout", ring, 1);
        run(1);
        check("ring_timeout", ring, 0);
        check("timeout_no_snooze", snoozing, 0);

        // Snooze then re-ring with the saved channels, then aoff.
        set_time(6, 59, 58);
        wait_ring(3 * TD + 4, "ring_on2");
        strobe(1'b0, 1'b1);
        check("snooze_ring", ring, 0);
        check("snooze_active", snoozing, 1);
        wait_ring((SNZN + 2) * TD, "snooze_rering");
        check("rering_mask", ring_mask, 5);
        strobe(1'b1, 1'b0);
        check("aoff_ring", ring, 0);
        check("aoff_snoozing", snoozing, 0);

        // aoff beats a coincident snooze.
        set_time(6, 59, 58);
        wait_ring(3 * TD + 4, "ring_on3");
        strobe(1'b1, 1'b1);
        check("aoff_snz_ring", ring, 0);
        check("aoff_snz_snoozing", snoozing, 0);

        // aoff on the match cycle drops the match.
        set_time(6, 59, 58);
        for (int k = 0; k < 3 * TD + 4 && !(m_pulse != 0 && m_tod == 25200); k++) cycle();
        check("hit_0700_pulse", sec_pulse, 1);
        strobe(1'b1, 1'b0);
        check("aoff_match_ring", ring, 0);
        run(TD);
        check("aoff_match_later", ring, 0);

        // Async reset mid-ring and mid-snooze.
        set_time(6, 59, 58);
        wait_ring(3 * TD + 4, "ring_on4");
        do_reset();
        check("rst_ring", ring, 0);
        check("rst_mask", ring_mask, 0);
        check("rst_sec", sec, 0);
        write_alarm(1, 7, 0, 1);
        set_time(6, 59, 58);
        wait_ring(3 * TD + 4, "ring_on5");
        strobe(1'b0, 1'b1);
        run(10);
        check("pre_rst_snoozing", snoozing, 1);
        do_reset();
        check("rst_snoozing", snoozing, 0);
        set_time(6, 59, 58);
        run(4 * TD);
        check("alarm_disabled", ring, 0);

`ifdef WATCH_CORE_HOUR12_EN
        set_time(0, 30, 0);
        check("h12_0030_hour", hour, 12);
        check("h12_0030_pm", pm, 0);
        set_time(13, 5, 0);
        check("h12_1305_hour", hour, 1);
        check("h12_1305_pm", pm, 1);
`endif

        // Random traffic against the model.
        $display("random phase");
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 4) begin
                set_hour = 5'($urandom_range(0, 25));
                set_min  = 6'($urandom_range(0, 61));
                set_sec  = 6'($urandom_range(50, 61));
                set_time_wr = 1'b1;
            end else if (r < 14) begin
                alm_idx  = 2'($urandom_range(0, 3));
                alm_hour = 5'(m_tod / 3600);
                alm_min  = 6'(((m_tod / 60) + 1) % 60);
                if ($urandom_range(0, 9) == 0) alm_min = 6'($urandom_range(60, 63));
                alm_en = ($urandom_range(0, 4) != 0);
                alm_wr = 1'b1;
            end
            aoff   = ($urandom_range(0, 399) == 0);
            snooze = ($urandom_range(0, 59) == 0);
            cycle();
            set_time_wr = 1'b0; alm_wr = 1'b0; aoff = 1'b0; snooze = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
